shift_window_rs: RTL and testbench
==================================

# shift_window_rs

Multi-channel successor to the single-lane window connecter. Each of `N_ch` signed `L_width`-bit lanes is reduced to an `S_width`-bit window at a per-channel bit offset, with optional round-half-up and overflow saturation. The block sits between wide accumulator/filter outputs and narrow DAC/telemetry paths. It adds a two-stage valid/ready pipeline with backpressure, shadowed shift configuration with atomic commit, and sticky overflow/config-error flags.

## Interface
- `L_width`, 32, input lane width (signed)
- `S_width`, 16, output lane width (signed); requires `L_width > S_width`
- `N_ch`, 2, number of channels
- `Shift_word`, 5, shift field width; must hold `L_width-S_width`

- `i_clkp`  in  1  clock; single domain
- `i_rstn`  in  1  asynchronous, active-low reset
- `i_valid`  in  1  input sample valid
- `o_ready`  out  1  block can accept a sample this cycle
- `i_data`  in  `N_ch*L_width`  lane k at `[k*L_width +: L_width]`
- `o_valid`  out  1  output sample valid
- `i_ready`  in  1  downstream accepts the output sample
- `o_data`  out  `N_ch*S_width`  lane k at `[k*S_width +: S_width]`
- `o_ovf`  out  `N_ch`  per-lane saturation occurred on the current output sample
- `o_ovf_sticky`  out  `N_ch`  latched OR of `o_ovf` on accepted outputs
- `i_ovf_clr`  in  1  clears `o_ovf_sticky` and `o_cfg_err`
- `i_rnd_en`  in  1  round-half-up enable (quasi-static)
- `i_sat_en`  in  1  saturation enable (quasi-static)
- `i_cfg_we`  in  1  write shadow shift
- `i_cfg_ch`  in  `clog2(N_ch)`  target channel
- `i_cfg_shift`  in  `Shift_word`  requested offset
- `i_cfg_commit`  in  1  copy all shadow shifts to active
- `o_cfg_err`  out  1  sticky: out-of-range shift or channel written

## Operation
- Window for lane k with active shift `sh`: `x[S_width+sh-1 : sh]`. Legal `sh` is 0..`L_width-S_width` inclusive.
- Config write with `sh > L_width-S_width` stores `L_width-S_width` and sets `o_cfg_err`. Write with `i_cfg_ch >= N_ch` is ignored and sets `o_cfg_err`.
- Commit copies shadow to active for all channels. A write in the same cycle as the commit is included in that commit (bypass).
- A sample accepted in the commit cycle uses the old active shifts. The next accepted sample uses the new ones.
- Rounding (`i_rnd_en=1`, `sh>0`):
  - add `2^(sh-1)` in `L_width+1`-bit signed arithmetic before selecting the window, so there is no wrap.
  - when `sh=0`, no rounding is applied.
- Saturation (`i_sat_en=1`): overflow occurs when the bits above the window (including the rounding carry bit) are not all equal to the window MSB.
  - output clamps to `2^(S_width-1)-1` if the source is non-negative, else `-2^(S_width-1)`.
  - `o_ovf[k]=1` on that sample.
- `i_sat_en=0`: the window is truncated (wraps) and `o_ovf` stays 0.
- `o_ovf_sticky` sets on an output handshake (`o_valid & i_ready`) with `o_ovf`. If `i_ovf_clr` and a set event coincide, the set wins.
- Reset values: `o_valid=0`, `o_data=0`, `o_ovf=0`, sticky flags 0, `o_cfg_err=0`, shadow and active shifts 0. `o_ready=1` once both stage-valid registers are 0, including during reset.

## Timing
- Stage 1: register the rounded, widened lane and the shift used.
- Stage 2: window selection plus saturation into the output registers.
- Latency is 2 cycles from input handshake to `o_valid`. Throughput is 1 sample/cycle when `i_ready=1`.
- Advance rules (combinational):
  - `s2_adv = ~s2_valid | i_ready`
  - `s1_adv = ~s1_valid | s2_adv`
  - `o_ready = s1_adv`
- While `o_valid & ~i_ready`, `o_data` and `o_ovf` are held stable.
- No sample is lost or duplicated. After `i_ready` drops, `o_ready` falls only once both stages are full.
- Reset asserted mid-stream clears both stages immediately (async), discarding in-flight samples.
- `i_rnd_en` and `i_sat_en` are sampled in stage 1 and stage 2 respectively. They should be changed only while idle; if changed mid-stream, the result is defined per stage and no glitch is allowed.

## Structure
- Package `shift_win_pkg`: `clog2` function, lane-slice helper functions, saturation-limit constants derived from `S_width`.
- Sub-module `shift_win_lane`: one channel's stage-1 and stage-2 data path, taking `sh`, `rnd_en`, `sat_en` and stage enables. It is instantiated `N_ch` times via generate.
- Top level holds the handshake/valid control, the shadow/active shift arrays and the sticky flags.

## Test plan
- Plain truncation: `L=32`, `S=16`, ch0 `sh=4`, `rnd=0`, `sat=0`, input `0x0001_2345` → `0x1234` two cycles after handshake, `o_ovf=0`.
- Rounding: `rnd=1`, `sh=4`:
  - input `0x0001_2348` → `0x1235`
  - input `0x0001_2347` → `0x1234`
- Saturation at `sh=0`, `sat=1`:
  - `0x0001_0000` → `0x7FFF` with `o_ovf=1` and sticky set
  - `0xFFFF_0000` → `0x8000`
  - with `sat=0`, both → `0x0000`
- Rounding carry: `sh=4`, `rnd=1`, `sat=1`, input `0x0007_FFF8` → `0x7FFF`, `o_ovf=1`. After `i_ovf_clr`, sticky reads 0.
- Backpressure: stream 6 consecutive samples, hold `i_ready=0` for 3 cycles mid-stream:
  - outputs appear in order with no loss or duplication
  - `o_data` is stable while stalled
  - `o_ready=0` only while both stages are full
- Configuration and reset:
  - write ch1 shift 17 → active becomes 16 after commit, `o_cfg_err=1`
  - commit in the same cycle as an input handshake → that sample uses the old shift, the next uses the new one
  - assert `i_rstn` low mid-stream → `o_valid=0` immediately and shifts read back 0

Source files
------------

// File: rtl/shift_win_pkg.sv
`default_nettype none
// ============================================================================
// shift_win_pkg : shared helpers for the multi-channel window shifter
// Rev 1.0
// ============================================================================
package shift_win_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int lane_lsb(input int k, input int w);
        return k * w;
    endfunction

    function automatic logic [63:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg(input int w);
        return ~sat_pos(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_win_lane.sv
`default_nettype none
// ============================================================================
// shift_win_lane : one channel's round (stage 1) and window/saturate (stage 2)
// Rev 1.0
// ============================================================================
module shift_win_lane
    import shift_win_pkg::*;
#(
    parameter int L_width    = 32,
    parameter int S_width    = 16,
    parameter int Shift_word = 5
) (
    input  logic                      i_clkp,
    input  logic                      i_rstn,
    input  logic                      i_s1_en,
    input  logic                      i_s2_en,
    input  logic signed [L_width-1:0] i_x,
    input  logic [Shift_word-1:0]     i_sh,
    input  logic                      i_rnd_en,
    input  logic                      i_sat_en,
    output logic [S_width-1:0]        o_y,
    output logic                      o_ovf
);

    localparam int                 WX      = L_width + 1;
    localparam logic [S_width-1:0] SAT_POS = S_width'(sat_pos(S_width));
    localparam logic [S_width-1:0] SAT_NEG = S_width'(sat_neg(S_width));

    logic signed [WX-1:0]     rnd_add;
    logic signed [WX-1:0]     s1_x_d;
    logic signed [WX-1:0]     s1_x_q;
    logic [Shift_word-1:0]    s1_sh_q;
    logic signed [WX-1:0]     shifted;
    logic [WX-S_width:0]      upper;
    logic                     ovf_d;
    logic [S_width-1:0]       y_d;
    logic [S_width-1:0]       y_q;
    logic                     ovf_q;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        rnd_add = '0;
        if (i_rnd_en && (i_sh != '0)) begin
            rnd_add = WX'(1) << (i_sh - 1'b1);
        end
        s1_x_d = {i_x[L_width-1], i_x} + rnd_add;
    end

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_x_q  <= '0;
            s1_sh_q <= '0;
        end else if (i_s1_en) begin
            s1_x_q  <= s1_x_d;
            s1_sh_q <= i_sh;
        end
    end

    // Everything from the window MSB upward must agree for the value to fit.
    always_comb begin
        shifted = s1_x_q >>> s1_sh_q;
        upper   = shifted[WX-1:S_width-1];
        ovf_d   = i_sat_en && !((&upper) || !(|upper));
        y_d     = shifted[S_width-1:0];
        if (ovf_d) begin
            y_d = s1_x_q[WX-1] ? SAT_NEG : SAT_POS;
        end
    end

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            y_q   <= '0;
            ovf_q <= 1'b0;
        end else if (i_s2_en) begin
            y_q   <= y_d;
            ovf_q <= ovf_d;
        end
    end

    assign o_y   = y_q;
    assign o_ovf = ovf_q;

endmodule
`default_nettype wire

// File: rtl/shift_window_rs.sv
`default_nettype none
// ============================================================================
// shift_window_rs : N-channel signed window shifter, 2-stage valid/ready pipe
// Rev 1.0
// ============================================================================
module shift_window_rs
    import shift_win_pkg::*;
#(
    parameter  int L_width    = 32,
    parameter  int S_width    = 16,
    parameter  int N_ch       = 2,
    parameter  int Shift_word = 5,
    localparam int CH_W       = (clog2(N_ch) > 0) ? clog2(N_ch) : 1
) (
    input  logic                      i_clkp,
    input  logic                      i_rstn,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [N_ch*L_width-1:0]   i_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [N_ch*S_width-1:0]   o_data,
    output logic [N_ch-1:0]           o_ovf,
    output logic [N_ch-1:0]           o_ovf_sticky,
    input  logic                      i_ovf_clr,
    input  logic                      i_rnd_en,
    input  logic                      i_sat_en,
    input  logic                      i_cfg_we,
    input  logic [CH_W-1:0]           i_cfg_ch,
    input  logic [Shift_word-1:0]     i_cfg_shift,
    input  logic                      i_cfg_commit,
    output logic                      o_cfg_err
);

    localparam logic [Shift_word-1:0] SH_MAX = Shift_word'(L_width - S_width);

    logic                  s1_valid_q;
    logic                  s2_valid_q;
    logic                  s1_adv;
    logic                  s2_adv;
    logic                  s1_load;
    logic                  s2_load;
    logic [Shift_word-1:0] shadow_d [N_ch];
    logic [Shift_word-1:0] shadow_q [N_ch];
    logic [Shift_word-1:0] active_d [N_ch];
    logic [Shift_word-1:0] active_q [N_ch];
    logic [Shift_word-1:0] sh_clip;
    logic                  ch_ok;
    logic                  err_set;
    logic                  cfg_err_d;
    logic                  cfg_err_q;
    logic [N_ch-1:0]       sticky_d;
    logic [N_ch-1:0]       sticky_q;

    assign s2_adv  = ~s2_valid_q | i_ready;
    assign s1_adv  = ~s1_valid_q | s2_adv;
    assign s1_load = s1_adv & i_valid;
    assign s2_load = s2_adv & s1_valid_q;
    assign o_ready = s1_adv;
    assign o_valid = s2_valid_q;

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (s1_adv) s1_valid_q <= i_valid;
            if (s2_adv) s2_valid_q <= s1_valid_q;
        end
    end

    assign ch_ok   = int'(i_cfg_ch) < N_ch;
    assign sh_clip = (i_cfg_shift > SH_MAX) ? SH_MAX : i_cfg_shift;
    assign err_set = i_cfg_we && (!ch_ok || (i_cfg_shift > SH_MAX));

    // Commit reads shadow_d so a same-cycle write is folded into the commit.
    always_comb begin
        for (int k = 0; k < N_ch; k++) begin
            shadow_d[k] = shadow_q[k];
            if (i_cfg_we && (int'(i_cfg_ch) == k)) shadow_d[k] = sh_clip;
            active_d[k] = i_cfg_commit ? shadow_d[k] : active_q[k];
        end
        cfg_err_d = (i_ovf_clr ? 1'b0 : cfg_err_q) | err_set;
        sticky_d  = (i_ovf_clr ? '0 : sticky_q) | ({N_ch{s2_valid_q & i_ready}} & o_ovf);
    end

    always_ff @(posedge i_clkp or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < N_ch; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
            cfg_err_q <= 1'b0;
            sticky_q  <= '0;
        end else begin
            for (int k = 0; k < N_ch; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
            cfg_err_q <= cfg_err_d;
            sticky_q  <= sticky_d;
        end
    end

    assign o_cfg_err    = cfg_err_q;
    assign o_ovf_sticky = sticky_q;

    generate
        for (genvar k = 0; k < N_ch; k++) begin : g_lane
            shift_win_lane #(
                .L_width    (L_width),
                .S_width    (S_width),
                .Shift_word (Shift_word)
            ) u_lane (
                .i_clkp   (i_clkp),
                .i_rstn   (i_rstn),
                .i_s1_en  (s1_load),
                .i_s2_en  (s2_load),
                .i_x      (i_data[lane_lsb(k, L_width) +: L_width]),
                .i_sh     (active_q[k]),
                .i_rnd_en (i_rnd_en),
                .i_sat_en (i_sat_en),
                .o_y      (o_data[lane_lsb(k, S_width) +: S_width]),
                .o_ovf    (o_ovf[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_shift_window_rs.sv
`default_nettype none
// ============================================================================
// tb_shift_window_rs : directed self-checking bench for shift_window_rs
// Rev 1.0
// ============================================================================
module tb_shift_window_rs;

    logic        i_clkp = 1'b0;
    logic        i_rstn;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic [1:0]  o_ovf;
    logic [1:0]  o_ovf_sticky;
    logic        i_ovf_clr;
    logic        i_rnd_en;
    logic        i_sat_en;
    logic        i_cfg_we;
    logic [0:0]  i_cfg_ch;
    logic [4:0]  i_cfg_shift;
    logic        i_cfg_commit;
    logic        o_cfg_err;

    int n_checks = 0;
    int n_errs   = 0;
    logic [33:0] obs_q [$];
    int          drv_k;
    logic        hs;
    logic [33:0] exp_e;

    shift_window_rs dut (
        .i_clkp       (i_clkp),
        .i_rstn       (i_rstn),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_ovf        (o_ovf),
        .o_ovf_sticky (o_ovf_sticky),
        .i_ovf_clr    (i_ovf_clr),
        .i_rnd_en     (i_rnd_en),
        .i_sat_en     (i_sat_en),
        .i_cfg_we     (i_cfg_we),
        .i_cfg_ch     (i_cfg_ch),
        .i_cfg_shift  (i_cfg_shift),
        .i_cfg_commit (i_cfg_commit),
        .o_cfg_err    (o_cfg_err)
    );

    always #5 i_clkp = ~i_clkp;

    // Record every output that will be accepted on the coming rising edge.
    always @(negedge i_clkp) begin
        if (i_rstn && o_valid && i_ready) obs_q.push_back({o_ovf, o_data});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clkp);
        #1;
    endtask

    task automatic cfg_write(input logic ch, input logic [4:0] sh);
        i_cfg_we = 1'b1; i_cfg_ch = ch; i_cfg_shift = sh;
        step();
        i_cfg_we = 1'b0;
    endtask

    task automatic commit();
        i_cfg_commit = 1'b1;
        step();
        i_cfg_commit = 1'b0;
    endtask

    task automatic pulse_clr();
        i_ovf_clr = 1'b1;
        step();
        i_ovf_clr = 1'b0;
    endtask

    task automatic run_sample(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [15:0] e0, input logic [15:0] e1, input logic [1:0] eovf);
        int lat;
        bit found;
        i_data  = {d1, d0};
        i_valid = 1'b1;
        @(negedge i_clkp);
        check({tag, "_rdy"}, 64'(o_ready), 64'd1);
        step();
        i_valid = 1'b0;
        lat   = 0;
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            @(negedge i_clkp);
            lat++;
            if (o_valid) found = 1'b1;
        end
        check({tag, "_seen"}, 64'(found), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'd2);
        check({tag, "_data"}, 64'(o_data), 64'({e1, e0}));
        check({tag, "_ovf"}, 64'(o_ovf), 64'(eovf));
        step();
    endtask

    initial begin
        i_rstn = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
        i_ovf_clr = 1'b0; i_rnd_en = 1'b0; i_sat_en = 1'b0;
        i_cfg_we = 1'b0; i_cfg_ch = '0; i_cfg_shift = '0; i_cfg_commit = 1'b0;

        // Reset state
        #1;
        check("rst_ovalid", 64'(o_valid), 64'd0);
        check("rst_oready", 64'(o_ready), 64'd1);
        check("rst_odata", 64'(o_data), 64'd0);
        check("rst_sticky", 64'(o_ovf_sticky), 64'd0);
        check("rst_cfgerr", 64'(o_cfg_err), 64'd0);
        repeat (2) @(negedge i_clkp);
        i_rstn = 1'b1;
        step();

        // Plain truncation, ch0 sh=4, ch1 sh=0
        cfg_write(1'b0, 5'd4);
        commit();
        run_sample("trunc", 32'h0001_2345, 32'h0001_2345, 16'h1234, 16'h2345, 2'b00);

        // Round-half-up; sh=0 lane is never rounded
        i_rnd_en = 1'b1;
        run_sample("rnd_up", 32'h0001_2348, 32'h0000_0005, 16'h1235, 16'h0005, 2'b00);
        run_sample("rnd_dn", 32'h0001_2347, 32'hFFFF_FFFF, 16'h1234, 16'hFFFF, 2'b00);

        // Saturation at sh=0 both polarities, then wrap with saturation off
        i_rnd_en = 1'b0;
        cfg_write(1'b0, 5'd0);
        commit();
        i_sat_en = 1'b1;
        run_sample("sat", 32'h0001_0000, 32'hFFFF_0000, 16'h7FFF, 16'h8000, 2'b11);
        @(negedge i_clkp);
        check("sat_sticky", 64'(o_ovf_sticky), 64'd3);
        step();
        i_sat_en = 1'b0;
        run_sample("wrap", 32'h0001_0000, 32'hFFFF_0000, 16'h0000, 16'h0000, 2'b00);
        @(negedge i_clkp);
        check("wrap_sticky", 64'(o_ovf_sticky), 64'd3);
        step();
        pulse_clr();
        @(negedge i_clkp);
        check("clr_sticky", 64'(o_ovf_sticky), 64'd0);
        step();

        // Rounding carry into the bit above the window
        cfg_write(1'b0, 5'd4);
        commit();
        i_rnd_en = 1'b1; i_sat_en = 1'b1;
        run_sample("carry", 32'h0007_FFF8, 32'h0000_1234, 16'h7FFF, 16'h1234, 2'b01);
        @(negedge i_clkp);
        check("carry_sticky", 64'(o_ovf_sticky), 64'd1);
        check("carry_cfgerr", 64'(o_cfg_err), 64'd0);
        step();
        pulse_clr();
        @(negedge i_clkp);
        check("carry_clr", 64'(o_ovf_sticky), 64'd0);
        step();

        // Out-of-range shift is clamped to L-S and flagged
        i_rnd_en = 1'b0; i_sat_en = 1'b0;
        cfg_write(1'b1, 5'd17);
        @(negedge i_clkp);
        check("cfg_err_set", 64'(o_cfg_err), 64'd1);
        step();
        commit();
        run_sample("sh16", 32'h0001_2345, 32'h0001_2345, 16'h1234, 16'h0001, 2'b00);
        pulse_clr();
        @(negedge i_clkp);
        check("cfg_err_clr", 64'(o_cfg_err), 64'd0);
        step();

        // Commit coinciding with a handshake: that sample keeps old shifts
        cfg_write(1'b0, 5'd8);
        obs_q.delete();
        i_data = {32'h00AB_CDEF, 32'h0001_2345};
        i_valid = 1'b1; i_cfg_commit = 1'b1;
        step();
        i_cfg_commit = 1'b0;
        step();
        i_valid = 1'b0;
        for (int n = 0; n < 10 && obs_q.size() < 2; n++) @(negedge i_clkp);
        check("cmt_count", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() >= 2) begin
            check("cmt_old", 64'(obs_q[0]), 64'({2'b00, 16'h00AB, 16'h1234}));
            check("cmt_new", 64'(obs_q[1]), 64'({2'b00, 16'h00AB, 16'h0123}));
        end
        step();

        // Backpressure: 6-sample stream, ready low for 3 cycles once both stages fill
        obs_q.delete();
        drv_k = 0;
        fork
            begin
                for (int g = 0; g < 100 && drv_k < 6; g++) begin
                    i_data  = {32'(drv_k + 1) << 16, 32'(drv_k + 1) << 8};
                    i_valid = 1'b1;
                    @(negedge i_clkp);
                    hs = o_ready;
                    step();
                    if (hs) drv_k++;
                end
                i_valid = 1'b0;
            end
            begin
                @(posedge i_clkp);
                @(posedge i_clkp);
                @(negedge i_clkp);
                check("bp_rdy_flow", 64'(o_ready), 64'd1);
                @(posedge i_clkp);
                @(posedge i_clkp);
                #1 i_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge i_clkp);
                    check("bp_rdy_full", 64'(o_ready), 64'd0);
                    check("bp_valid", 64'(o_valid), 64'd1);
                    check("bp_hold", 64'(o_data), 64'h0003_0003);
                end
                @(posedge i_clkp);
                #1 i_ready = 1'b1;
            end
        join
        check("bp_sent", 64'(drv_k), 64'd6);
        for (int n = 0; n < 20 && obs_q.size() < 6; n++) @(negedge i_clkp);
        check("bp_count", 64'(obs_q.size()), 64'd6);
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            exp_e = {2'b00, 16'(i + 1), 16'(i + 1)};
            check("bp_order", 64'(obs_q[i]), 64'(exp_e));
        end
        step();

        // Asynchronous reset mid-stream
        i_data = {32'h0001_0000, 32'h0000_0100};
        i_valid = 1'b1;
        step();
        step();
        #2 i_rstn = 1'b0;
        #1;
        check("arst_ovalid", 64'(o_valid), 64'd0);
        check("arst_oready", 64'(o_ready), 64'd1);
        check("arst_odata", 64'(o_data), 64'd0);
        i_valid = 1'b0;
        @(negedge i_clkp);
        i_rstn = 1'b1;
        step();
        run_sample("arst_sh0", 32'h0001_2345, 32'h0001_2345, 16'h2345, 16'h2345, 2'b00);
        check("arst_cfgerr", 64'(o_cfg_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
